// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue controller and its opcode decoder:
//   - 4-bit ALU control codes (AND, OR, ADD, SUB, PassB)
//   - LEGv8 opcode constants, including the 8-bit CBZ prefix
//   - issue FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int OPC_W = 11;

   // ALU control codes understood by the combinational ALU
   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   // LEGv8 opcodes
   localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
   localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
   localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
   localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;
   localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
   localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;
   // CBZ only fixes the upper eight bits; the low three are don't-care
   localparam logic [7:0]       OPC_CBZ_PFX = 8'b10110100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Combinational LEGv8 opcode -> ALU control decoder.
// Ports:
//   opcode  in  [10:0] LEGv8 opcode field
//   ctrl    out [3:0]  ALU control code (PassB for illegal opcodes)
//   illegal out        opcode not in the supported set
// -----------------------------------------------------------------------------
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   output logic [3:0]       ctrl,
   output logic             illegal
);

   // Opcode table lookup; CBZ is matched on its prefix before the exact table
   always_comb begin
      ctrl    = ALU_PASSB;
      illegal = 1'b0;
      if (opcode[OPC_W-1:3] == OPC_CBZ_PFX) begin
         ctrl    = ALU_PASSB;
         illegal = 1'b0;
      end else begin
         case (opcode)
            OPC_ADD:  ctrl = ALU_ADD;
            OPC_SUB:  ctrl = ALU_SUB;
            OPC_AND:  ctrl = ALU_AND;
            OPC_ORR:  ctrl = ALU_OR;
            OPC_LDUR: ctrl = ALU_ADD;
            OPC_STUR: ctrl = ALU_ADD;
            default: begin
               ctrl    = ALU_PASSB;
               illegal = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Initiator side of the 64-bit combinational ALU. Takes an opcode and two
// operands over a valid/ready request channel, drives the ALU from registered
// operands for one cycle, captures BusW/Zero and returns them over a
// valid/ready response channel. One operation every three cycles at most.
//
// Optional feature macro: ALU_FLAGS_EN adds rsp_flags = {N,Z,C,V}.
//
// Ports:
//   CLK, resetl              clock (rising edge), async active-low reset
//   req_valid/req_ready      request handshake
//   req_opcode, req_a, req_b request payload
//   alu_ctrl, alu_a, alu_b   registered drive to the ALU
//   alu_w, alu_zero          ALU result inputs
//   rsp_valid/rsp_ready      response handshake
//   rsp_result, rsp_zero     captured ALU outputs
//   rsp_err                  opcode was illegal
//   rsp_flags (ALU_FLAGS_EN) captured {N,Z,C,V}
// -----------------------------------------------------------------------------
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DW  = 64,
   parameter int OPW = OPC_W
) (
   input  logic           CLK,
   input  logic           resetl,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [OPW-1:0] req_opcode,
   input  logic [DW-1:0]  req_a,
   input  logic [DW-1:0]  req_b,
   output logic [3:0]     alu_ctrl,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   input  logic [DW-1:0]  alu_w,
   input  logic           alu_zero,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [DW-1:0]  rsp_result,
   output logic           rsp_zero,
   output logic           rsp_err
`ifdef ALU_FLAGS_EN
   ,
   output logic [3:0]     rsp_flags
`endif
);

   state_t     state;
   logic       err;
   logic [3:0] dec_ctrl;
   logic       dec_illegal;

   alu_op_decode u_dec (
      .opcode  (req_opcode),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal)
   );

`ifdef ALU_FLAGS_EN
   logic [DW:0]   add_sum;
   logic [DW-1:0] sub_diff;
   logic          flag_c;
   logic          flag_v;

   // Carry and overflow for the op currently on the ALU drive
   always_comb begin
      add_sum  = {1'b0, alu_a} + {1'b0, alu_b};
      sub_diff = alu_a - alu_b;
      flag_c   = 1'b0;
      flag_v   = 1'b0;
      case (alu_ctrl)
         ALU_ADD: begin
            flag_c = add_sum[DW];
            flag_v = (alu_a[DW-1] == alu_b[DW-1]) && (add_sum[DW-1] != alu_a[DW-1]);
         end
         ALU_SUB: begin
            // carry means "no borrow" for subtraction
            flag_c = (alu_a >= alu_b);
            flag_v = (alu_a[DW-1] != alu_b[DW-1]) && (sub_diff[DW-1] != alu_a[DW-1]);
         end
         default: begin
            flag_c = 1'b0;
            flag_v = 1'b0;
         end
      endcase
   end
`endif

   // Issue FSM: accept, drive ALU for one cycle, capture, hold response
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state      <= ST_IDLE;
         req_ready  <= 1'b0;
         alu_ctrl   <= 4'b0000;
         alu_a      <= '0;
         alu_b      <= '0;
         err        <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
`ifdef ALU_FLAGS_EN
         rsp_flags  <= 4'b0000;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  // Illegal ops still run through the ALU as a harmless PassB of 0
                  if (dec_illegal) begin
                     alu_ctrl <= ALU_PASSB;
                     alu_a    <= '0;
                     alu_b    <= '0;
                     err      <= 1'b1;
                  end else begin
                     alu_ctrl <= dec_ctrl;
                     alu_a    <= req_a;
                     alu_b    <= req_b;
                     err      <= 1'b0;
                  end
                  req_ready <= 1'b0;
                  state     <= ST_EXEC;
               end else begin
                  // also raises ready on the first edge after reset release
                  req_ready <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (err) begin
                  rsp_result <= '0;
                  rsp_zero   <= 1'b0;
               end else begin
                  rsp_result <= alu_w;
                  rsp_zero   <= alu_zero;
               end
`ifdef ALU_FLAGS_EN
               if (err) begin
                  rsp_flags <= 4'b0000;
               end else begin
                  rsp_flags <= {alu_w[DW-1], alu_zero, flag_c, flag_v};
               end
`endif
               rsp_err   <= err;
               rsp_valid <= 1'b1;
               state     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  // stall: response fields simply hold
                  rsp_valid <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the 64-bit ALU interface (BusA/BusB/ALUCtrl in, BusW/Zero out).
- Accepts a LEGv8 11-bit opcode plus two 64-bit operands over a valid/ready request channel.
- Decodes the opcode to a 4-bit ALU control code, drives the ALU from registered operands, then captures BusW/Zero.
- Returns the result over a valid/ready response channel.
- Sits between the multi-cycle datapath sequencer and the existing combinational ALU.

Parameters:
- DW, 64, operand/result width; must match the ALU bus width.
- OPW, 11, opcode width (LEGv8 R/D-format opcode field).

Ports:
- CLK  input  1  single clock, rising edge
- resetl  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_opcode  input  OPW  LEGv8 opcode
- req_a  input  DW  operand A
- req_b  input  DW  operand B
- alu_ctrl  output  4  drives ALU ALUCtrl
- alu_a  output  DW  drives ALU BusA
- alu_b  output  DW  drives ALU BusB
- alu_w  input  DW  ALU BusW
- alu_zero  input  1  ALU Zero
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  DW  captured ALU result
- rsp_zero  output  1  captured Zero
- rsp_err  output  1  opcode was illegal

Behaviour:
- Reset (resetl=0, asynchronous):
  - state=IDLE.
  - alu_ctrl=4'b0000, alu_a=0, alu_b=0.
  - rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0.
  - req_ready=0 while resetl=0; req_ready=1 in the first cycle after release.
  - Reset mid-operation abandons the transaction; no response is produced.
- Decode (combinational):
  - 10001011000 ADD -> 0010
  - 11001011000 SUB -> 0110
  - 10001010000 AND -> 0000
  - 10101010000 ORR -> 0001
  - 11111000010 LDUR -> 0010
  - 11111000000 STUR -> 0010
  - 10110100xxx CBZ -> 0111 (PassB)
  - Any other opcode is illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: register alu_a/alu_b/alu_ctrl from the request and decode, then go to EXEC.
  - Illegal opcode: register alu_ctrl=0111 and operands 0, set err flag.
- EXEC:
  - req_ready=0.
  - The ALU settles combinationally on the registered drive.
  - At the clock edge: rsp_result=alu_w and rsp_zero=alu_zero, or 0/0 when err; rsp_err=err; go to RESP.
- RESP:
  - rsp_valid=1; response fields held stable until accepted.
  - On rsp_ready: go to IDLE; rsp_valid falls the next cycle.
  - rsp_ready=0 stalls indefinitely; req_ready stays 0.
- Latency and throughput:
  - Request accepted at edge N; rsp_valid=1 from edge N+2.
  - Maximum throughput is one op per 3 cycles; with rsp_ready tied high, req_ready reasserts at N+3.
- Width rules: ADD/SUB wrap modulo 2^DW; no saturation.
- Drive stability:
  - alu_ctrl/alu_a/alu_b change only on request accept.
  - Only the five defined ALU codes are ever driven.
- Simultaneous events:
  - rsp_ready asserted outside RESP is ignored.
  - req_valid asserted outside IDLE is not accepted; the requester must hold it.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined:
  - Adds output rsp_flags[3:0] = {N,Z,C,V}, captured at the EXEC edge.
  - N = alu_w[DW-1].
  - Z = alu_zero.
  - For ADD/LDUR/STUR: C = carry-out of alu_a+alu_b (computed internally at DW+1 bits); V = signed overflow.
  - For SUB: C = no-borrow (alu_a >= alu_b unsigned); V = signed overflow of a-b.
  - For other ops: C=V=0.
  - Reset value 0.
- Undefined: the port is absent and there is no flag logic.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control code constants (AND, OR, ADD, SUB, PassB).
  - LEGv8 opcode constants, including the CBZ 8-bit prefix.
  - FSM state encoding.
- One sub-module, alu_op_decode: combinational opcode -> {ctrl[3:0], illegal}. It is reused by the control unit.

Test Plan:
- ADD: opcode 10001011000, a=5, b=7, rsp_ready=1 -> alu_ctrl=0010 at N+1; rsp_valid at N+2 with result=12, zero=0, err=0.
- SUB: a=9, b=9 -> result=0, zero=1. With ALU_FLAGS_EN: flags=0110.
- SUB: a=0, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF. With ALU_FLAGS_EN: flags=1000.
- ADD wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, zero=1. With ALU_FLAGS_EN: flags=0110.
- CBZ backpressure: opcode 10110100101, b=0x10, rsp_ready held 0 for 5 cycles.
  - result=0x10, zero=0.
  - rsp_valid and fields stable throughout; req_ready=0 throughout.
  - Accepted on the cycle rsp_ready rises.
- Illegal opcode 00000000000 -> rsp_err=1, result=0, zero=0. A subsequent ORR with a=0xF0, b=0x0F returns result=0xFF, err=0.
- Reset mid-op: resetl pulled low in EXEC -> all outputs 0 immediately; after release req_ready=1, rsp_valid never asserts for the aborted op.
